// File: rtl/hex_keypad_pkg.sv
// Shared definitions for the hex keypad emulator: FSM state encoding,
// key-code field positions and the contact bounce toggle period.
package hex_keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESS   = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  // Key code layout: row in [3:2], column in [1:0]
  localparam int unsigned ROW_MSB = 3;
  localparam int unsigned ROW_LSB = 2;
  localparam int unsigned COL_MSB = 1;
  localparam int unsigned COL_LSB = 0;

  // Contact toggles every BOUNCE_PERIOD cycles while bouncing
  localparam int unsigned BOUNCE_PERIOD = 4;

endpackage

// File: rtl/keypad_emu_fifo.sv
// Key-code queue for the keypad emulator: 4-bit entries, FIFO_DEPTH deep
// (power of two), wrap-bit pointers for full/empty detection.
module keypad_emu_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_push,
  input  logic [3:0] i_wr_data,
  input  logic       i_pop,
  output logic [3:0] o_rd_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [3:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_wr_en;
  logic        w_rd_en;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_en   = i_push && !o_full;
  assign w_rd_en   = i_pop && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; push and pop in the same cycle both take effect
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage write, no reset needed on data
  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/hex_keypad_emulator.sv
// Hex keypad emulator: plays queued key codes as contact closures on a
// 4x4 matrix driven by a scanner under test.
// Optional contact bounce in PRESS/RELEASE: define KEYPAD_EMU_BOUNCE_EN.
module hex_keypad_emulator
  import hex_keypad_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 1000,
  parameter int unsigned GAP_CYCLES    = 500,
  parameter int unsigned FIFO_DEPTH    = 4
`ifdef KEYPAD_EMU_BOUNCE_EN
  , parameter int unsigned BOUNCE_CYCLES = 16
`endif
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       pressed,
  output logic [3:0] cur_code,
  output logic       busy,
  output logic       key_done
);

  localparam int unsigned MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int unsigned MAX_CYC = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
`else
  localparam int unsigned MAX_CYC = MAX_HG;
`endif
  localparam int unsigned CW = $clog2(MAX_CYC + 1);

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_contact, w_contact_nxt;
  logic [3:0]      r_cur_code;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [3:0]      w_head;
  logic [3:0]      w_row;
  logic [CW-1:0]   w_cnt_inc;
`ifdef KEYPAD_EMU_BOUNCE_EN
  logic            w_inc_phase;
  logic            w_inc_last_b;
`endif

  keypad_emu_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_push    (key_valid),
    .i_wr_data (key_code),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_cnt_inc = r_cnt + CW'(1);
`ifdef KEYPAD_EMU_BOUNCE_EN
  // Contact level for the next bounce cycle is derived from the incremented
  // count so the registered flag lines up with that cycle; the last cycle is
  // forced to the settled level.
  assign w_inc_phase  = ((32'(w_cnt_inc) / BOUNCE_PERIOD) & 32'd1) != 32'd0;
  assign w_inc_last_b = (w_cnt_inc == CW'(BOUNCE_CYCLES - 1));
`endif

  // State, counter, contact flag and current code registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_contact  <= 1'b0;
      r_cur_code <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_contact <= w_contact_nxt;
      if (w_pop) r_cur_code <= w_head;
    end
  end

  // Next-state, counter and next contact level
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_contact_nxt = r_contact;
    w_pop         = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_cnt_nxt     = '0;
        w_contact_nxt = 1'b0;
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_contact_nxt = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
          w_state_nxt   = ST_PRESS;
`else
          w_state_nxt   = ST_HOLD;
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_PRESS: begin
        if (r_cnt == CW'(BOUNCE_CYCLES - 1)) begin
          w_cnt_nxt     = '0;
          w_contact_nxt = 1'b1;
          w_state_nxt   = ST_HOLD;
        end else begin
          w_cnt_nxt     = w_cnt_inc;
          w_contact_nxt = w_inc_last_b ? 1'b1 : !w_inc_phase;
        end
      end
      ST_RELEASE: begin
        if (r_cnt == CW'(BOUNCE_CYCLES - 1)) begin
          w_cnt_nxt     = '0;
          w_contact_nxt = 1'b0;
          w_state_nxt   = ST_GAP;
        end else begin
          w_cnt_nxt     = w_cnt_inc;
          w_contact_nxt = w_inc_last_b ? 1'b0 : w_inc_phase;
        end
      end
`endif
      ST_HOLD: begin
        if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
          w_cnt_nxt     = '0;
          w_contact_nxt = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
          w_state_nxt   = ST_RELEASE;
`else
          w_state_nxt   = ST_GAP;
`endif
        end else begin
          w_cnt_nxt     = w_cnt_inc;
          w_contact_nxt = 1'b1;
        end
      end
      ST_GAP: begin
        w_contact_nxt = 1'b0;
        if (r_cnt == CW'(GAP_CYCLES - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      default: begin
        w_cnt_nxt     = '0;
        w_contact_nxt = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
    endcase
  end

  // Matrix return path: only the key's own row/column, zero latency on col_in
  always_comb begin
    w_row = '0;
    if (r_contact && col_in[r_cur_code[COL_MSB:COL_LSB]])
      w_row[r_cur_code[ROW_MSB:ROW_LSB]] = 1'b1;
  end

  assign row_out   = w_row;
  assign pressed   = r_contact;
  assign cur_code  = r_cur_code;
  assign key_ready = !w_full;
  assign busy      = (r_state != ST_IDLE) || !w_empty;
  assign key_done  = (r_state == ST_GAP) && (r_cnt == CW'(GAP_CYCLES - 1));

endmodule

// File: tb/tb_hex_keypad_emulator.sv
// Directed self-checking bench for hex_keypad_emulator (small hold/gap
// parameters). Bounce-specific expectations apply when
// KEYPAD_EMU_BOUNCE_EN is defined.
module tb_hex_keypad_emulator;

  localparam int H = 8;
  localparam int G = 5;
  localparam int D = 4;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int B        = 16;
  localparam int EXP_HIGH = H + 16;
  localparam int EXP_LAST = 1 + B + H + 14;
  localparam int EXP_DONE = 2 * B + H + G;
`else
  localparam int EXP_HIGH = H;
  localparam int EXP_LAST = H;
  localparam int EXP_DONE = H + G;
`endif
  localparam int LOOP = EXP_DONE + 6;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       pressed;
  logic [3:0] cur_code;
  logic       busy;
  logic       key_done;

  int n_assert = 0;
  int n_fail   = 0;

  hex_keypad_emulator #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .FIFO_DEPTH  (D)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .col_in    (col_in),
    .row_out   (row_out),
    .pressed   (pressed),
    .cur_code  (cur_code),
    .busy      (busy),
    .key_done  (key_done)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pressed(input int unsigned lim, output logic ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < lim; i++) begin
      if (pressed) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic wait_idle(input int unsigned lim, output logic ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < lim; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  logic [3:0] codes [5];
  logic [3:0] exp_row;
  logic       ok;
  logic       prev;
  int high, first, last, done_n, done_idx, bad, k, extra, trans, run, max_run;

  initial begin
    codes[0] = 4'h0; codes[1] = 4'h5; codes[2] = 4'hA; codes[3] = 4'hF; codes[4] = 4'h3;
    reset_n   = 1'b0;
    key_code  = 4'h0;
    key_valid = 1'b0;
    col_in    = 4'b0000;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_row_out",   row_out,   4'b0000);
    check("rst_pressed",   pressed,   1'b0);
    check("rst_cur_code",  cur_code,  4'h0);
    check("rst_key_done",  key_done,  1'b0);
    check("rst_busy",      busy,      1'b0);
    check("rst_key_ready", key_ready, 1'b1);
    reset_n = 1'b1;
    @(negedge clock);

    // Single key 0x6 on column 2 -> row 1
    key_code = 4'h6; key_valid = 1'b1; col_in = 4'b0100;
    @(negedge clock);
    key_valid = 1'b0;
    check("single_busy_queued", busy, 1'b1);
    check("single_open_before", pressed, 1'b0);
    high = 0; first = 0; last = 0; done_n = 0; done_idx = 0; bad = 0;
    for (int n = 1; n <= LOOP; n++) begin
      @(negedge clock);
      if (n == 1) check("single_cur_code", cur_code, 4'h6);
      if (row_out == 4'b0010) begin
        high++;
        if (first == 0) first = n;
        last = n;
      end else if (row_out != 4'b0000) begin
        bad++;
      end
      if (key_done) begin
        done_n++;
        done_idx = n;
      end
    end
    check("single_row_cycles", high, EXP_HIGH);
    check("single_row_first",  first, 1);
    check("single_row_last",   last, EXP_LAST);
    check("single_row_bad",    bad, 0);
    check("single_done_count", done_n, 1);
    check("single_done_cycle", done_idx, EXP_DONE);
    check("single_idle_busy",  busy, 1'b0);

    // Wrong column, then same-cycle response to col_in changes
    key_code = 4'h6; key_valid = 1'b1; col_in = 4'b0001;
    @(negedge clock);
    key_valid = 1'b0;
    wait_pressed(10, ok);
    check("wcol_pressed_seen", ok, 1'b1);
    check("wcol_row_zero", row_out, 4'b0000);
    col_in = 4'b0100; #1;
    check("wcol_row_own_col", row_out, 4'b0010);
    col_in = 4'b1111; #1;
    check("wcol_row_all_cols", row_out, 4'b0010);
    col_in = 4'b1011; #1;
    check("wcol_row_others_only", row_out, 4'b0000);
    wait_idle(LOOP + 10, ok);
    check("wcol_idle_reached", ok, 1'b1);
    col_in = 4'b0000; #1;
    check("open_row_zero", row_out, 4'b0000);

    // Queue full: five back-to-back pushes, one code in play
    @(negedge clock);
    col_in = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("q_ready_%0d", i), key_ready, 1'b1);
      key_code = codes[i]; key_valid = 1'b1;
      @(negedge clock);
    end
    key_code = 4'h9;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("q_full_ready_%0d", i), key_ready, 1'b0);
      @(negedge clock);
    end
    key_valid = 1'b0;
    check("q_busy", busy, 1'b1);
    k = 0; bad = 0;
    for (int n = 0; n < 5 * (EXP_DONE + 2) + 20; n++) begin
      if (pressed) begin
        exp_row = 4'b0001 << cur_code[3:2];
        if (row_out != exp_row) bad++;
      end
      if (key_done) begin
        if (k < 5) check($sformatf("q_order_%0d", k), cur_code, codes[k]);
        k++;
      end
      if (k >= 5 && !busy) break;
      @(negedge clock);
    end
    check("q_done_count", k, 5);
    check("q_row_bad", bad, 0);
    check("q_idle_busy", busy, 1'b0);
    extra = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (key_done || pressed) extra++;
    end
    check("q_no_sixth_key", extra, 0);

    // Reset mid-key with two codes queued
    key_code = 4'h1; key_valid = 1'b1;
    @(negedge clock);
    key_code = 4'h2;
    @(negedge clock);
    key_code = 4'h3;
    @(negedge clock);
    key_valid = 1'b0;
    check("rmid_pressed", pressed, 1'b1);
    check("rmid_busy", busy, 1'b1);
    check("rmid_row", row_out, 4'b0001);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("rmid_row_out",   row_out,   4'b0000);
    check("rmid_pressed_0", pressed,   1'b0);
    check("rmid_busy_0",    busy,      1'b0);
    check("rmid_key_ready", key_ready, 1'b1);
    check("rmid_cur_code",  cur_code,  4'h0);
    extra = 0;
    for (int n = 0; n < LOOP + 10; n++) begin
      @(negedge clock);
      if (key_done || pressed) extra++;
    end
    check("rmid_no_activity", extra, 0);

`ifdef KEYPAD_EMU_BOUNCE_EN
    // Bounce profile: 4 toggles in PRESS, 4 in RELEASE, steady hold between
    key_code = 4'h6; key_valid = 1'b1; col_in = 4'b0100;
    @(negedge clock);
    key_valid = 1'b0;
    prev = pressed; trans = 0; run = 0; max_run = 0;
    for (int n = 0; n < LOOP + 4; n++) begin
      @(negedge clock);
      if (pressed != prev) trans++;
      if (pressed) run++; else run = 0;
      if (run > max_run) max_run = run;
      prev = pressed;
    end
    check("bnc_transitions", trans, 10);
    check("bnc_longest_closed", max_run, H + 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
